mst_burst_engine: RTL and testbench
===================================

MST_BURST_ENGINE -- requirements
Module: mst_burst_engine

Interface
REQ-001 SHALL have parameters: AW 12 byte-address width; DW 32 data width; SW 4 byte-select width (DW/8); LW 8 burst-length field width.
REQ-002 SHALL have ports (clock and reset first):
 iClk  in  1  sole clock, rising edge
 iRst_n  in  1  reset, asynchronous, active-low
 iCmdValid  in  1  command offered
 oCmdReady  out  1  command accepted this cycle when iCmdValid high
 iCmdWr  in  1  1 = write burst, 0 = read burst
 iCmdAddr  in  AW  start byte address, word-aligned
 iCmdLen  in  LW  beats minus one (0 = 1 beat)
 iCmdSel  in  SW  byte select for all beats
 iWrDataValid  in  1  write-data word offered
 oWrDataReady  out  1  write-data word consumed
 iWrData  in  DW  write-data word
 oRdDataValid  out  1  read word valid, single-cycle
 oRdData  out  DW  read word
 oBusy  out  1  burst in progress
 oDone  out  1  one-cycle pulse at burst completion
 oMstWrReq, oMstWrValid  out  1 each  write request / beat valid to slave
 oMstWrAddr  out  AW;  oMstWrSel  out  SW;  oMstWrData  out  DW
 iMstWrReady  in  1  slave write ready
 oMstRdReq, oMstRdValid  out  1 each  read request / beat valid to slave
 oMstRdAddr  out  AW;  oMstRdSel  out  SW
 iMstRdReady  in  1  slave read ready
 iMstRdData  in  DW  slave read data, registered by slave, valid the cycle after beat accept

Function
REQ-003 SHALL implement FSM states IDLE, WR, RD, DRAIN.
REQ-004 oCmdReady SHALL equal 1 only in IDLE; a command is taken when iCmdValid && oCmdReady.
REQ-005 On command take: addr reg <= {iCmdAddr[AW-1:2],2'b00}, beat counter <= iCmdLen, sel reg <= iCmdSel; next state WR if iCmdWr, else RD.
REQ-006 In WR: oMstWrReq = 1; oMstWrValid = iWrDataValid; oMstWrData = iWrData; oWrDataReady = iMstWrReady (combinational pass-through, no buffering).
REQ-007 A write beat completes when oMstWrReq && oMstWrValid && iMstWrReady; a read beat when oMstRdReq && oMstRdValid && iMstRdReady.
REQ-008 In RD: oMstRdReq = 1, oMstRdValid = 1 every cycle until last beat completes.
REQ-009 Each completed beat: addr += 4, modulo 2^AW (wraps, no error); counter -= 1.
REQ-010 Beat completion with counter == 0: WR -> IDLE with oDone pulse same edge; RD -> DRAIN.
REQ-011 DRAIN SHALL last exactly one cycle, then IDLE; oDone pulses on DRAIN exit, coincident with last oRdDataValid.
REQ-012 oRdDataValid SHALL be registered high the cycle after each completed read beat; oRdData = iMstRdData in that cycle; reads are not back-pressurable.
REQ-013 oMstWr*/oMstRd* Req and Valid SHALL be 0 outside their own state; Addr/Sel reflect the registers.
REQ-014 oBusy SHALL be 1 in WR, RD, DRAIN.
REQ-015 Beat count per burst SHALL be iCmdLen+1, max 2^LW.
REQ-016 Stalls (iMstWrReady=0, iWrDataValid=0, iMstRdReady=0) SHALL hold addr, counter, state indefinitely.

Reset
REQ-017 iRst_n low SHALL force IDLE, counter 0, addr 0, sel 0, oRdDataValid 0, oDone 0, all Req/Valid 0, immediately and regardless of burst state; an aborted burst is not resumed.
REQ-018 First command acceptable on first rising edge after iRst_n deasserts.

Structure
REQ-019 FSM state encodings and the beat address stride (4) SHALL live in a shared bus package.
REQ-020 No sub-module required; single module, with slave_mem_model as the standard bench peer.

Verification
REQ-021 Write 4 beats at 0x010, sel 4'hF, data 1..4, slave ready tied 1 -> mem words 4..7 = 1..4, oDone after 4th beat.
REQ-022 Read 4 beats at 0x010 after REQ-021 -> oRdDataValid 4 cycles, data 1,2,3,4, oDone with 4th.
REQ-023 Write with iWrDataValid toggling 1/0 -> beats only on valid cycles, addresses strictly +4, no skipped word.
REQ-024 Write 2 beats at 0xFFC -> second beat addr 0x000 (wrap), oDone asserted.
REQ-025 Sel 4'b0101 write 0xAABBCCDD over 0x11223344 -> word reads 0x11BB33DD.
REQ-026 iRst_n low mid-read burst (beat 2 of 8) -> all Req/Valid 0, oBusy 0 asynchronously; new command accepted after release.

Source files
------------

// File: rtl/mst_burst_engine_pkg.sv
// Shared bus definitions for the burst master: FSM encodings and beat stride.
// No logic; constants and types only.
// Imported by every file of the burst engine.
package mst_burst_engine_pkg;

    // Burst engine control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR    = 2'd1,
        ST_RD    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Byte-address increment between consecutive beats (one 32-bit word)
    localparam int BEAT_STRIDE = 4;

endpackage

// File: rtl/mst_burst_engine.sv
// Burst master: turns one command into len+1 word beats on a slave write or read port.
// Latency: first beat offered the cycle after command take; read word returned one cycle after each beat accept.
// Backpressure: writes stall on iWrDataValid/iMstWrReady (pass-through); reads stall on iMstRdReady; read data is not back-pressurable.
module mst_burst_engine
    import mst_burst_engine_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = 32,
    parameter int SW = 4,
    parameter int LW = 8
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iCmdValid,
    output logic          oCmdReady,
    input  logic          iCmdWr,
    input  logic [AW-1:0] iCmdAddr,
    input  logic [LW-1:0] iCmdLen,
    input  logic [SW-1:0] iCmdSel,
    input  logic          iWrDataValid,
    output logic          oWrDataReady,
    input  logic [DW-1:0] iWrData,
    output logic          oRdDataValid,
    output logic [DW-1:0] oRdData,
    output logic          oBusy,
    output logic          oDone,
    output logic          oMstWrReq,
    output logic          oMstWrValid,
    output logic [AW-1:0] oMstWrAddr,
    output logic [SW-1:0] oMstWrSel,
    output logic [DW-1:0] oMstWrData,
    input  logic          iMstWrReady,
    output logic          oMstRdReq,
    output logic          oMstRdValid,
    output logic [AW-1:0] oMstRdAddr,
    output logic [SW-1:0] oMstRdSel,
    input  logic          iMstRdReady,
    input  logic [DW-1:0] iMstRdData
);

    // Word-alignment mask for the command start address
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BEAT_STRIDE - 1);
    localparam logic [AW-1:0] STRIDE     = AW'(BEAT_STRIDE);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr;
    logic [LW-1:0] cnt;
    logic [SW-1:0] sel;
    logic          rd_vld;
    logic          done;

    logic cmd_take;
    logic wr_beat;
    logic rd_beat;
    logic last_beat;

    assign cmd_take  = iCmdValid && oCmdReady;
    assign wr_beat   = oMstWrReq && oMstWrValid && iMstWrReady;
    assign rd_beat   = oMstRdReq && oMstRdValid && iMstRdReady;
    assign last_beat = (cnt == '0);

    // State register; reset aborts any burst in flight
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave a data state only on completion of the final beat
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cmd_take) state_nxt = iCmdWr ? ST_WR : ST_RD;
            ST_WR:    if (wr_beat && last_beat) state_nxt = ST_IDLE;
            ST_RD:    if (rd_beat && last_beat) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: handshakes only asserted inside their own state
    always_comb begin
        oCmdReady    = 1'b0;
        oWrDataReady = 1'b0;
        oMstWrReq    = 1'b0;
        oMstWrValid  = 1'b0;
        oMstRdReq    = 1'b0;
        oMstRdValid  = 1'b0;
        case (state)
            ST_IDLE: oCmdReady = 1'b1;
            ST_WR: begin
                oMstWrReq    = 1'b1;
                oMstWrValid  = iWrDataValid;
                oWrDataReady = iMstWrReady;
            end
            ST_RD: begin
                oMstRdReq   = 1'b1;
                oMstRdValid = 1'b1;
            end
            default: ;
        endcase
    end

    // Burst address / beat counter / byte select; hold on any stall
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            addr <= '0;
            cnt  <= '0;
            sel  <= '0;
        end else if (cmd_take) begin
            addr <= iCmdAddr & ALIGN_MASK;
            cnt  <= iCmdLen;
            sel  <= iCmdSel;
        end else if (wr_beat || rd_beat) begin
            addr <= addr + STRIDE;
            // Counter parks at zero after the final beat
            if (!last_beat) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Read-valid follows each read accept by one cycle; done marks the final beat
    // (for reads this lands in DRAIN, together with the last read word)
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rd_vld <= 1'b0;
            done   <= 1'b0;
        end else begin
            rd_vld <= rd_beat;
            done   <= (wr_beat || rd_beat) && last_beat;
        end
    end

    assign oBusy        = (state != ST_IDLE);
    assign oDone        = done;
    assign oRdDataValid = rd_vld;
    assign oRdData      = iMstRdData;
    assign oMstWrAddr   = addr;
    assign oMstWrSel    = sel;
    assign oMstWrData   = iWrData;
    assign oMstRdAddr   = addr;
    assign oMstRdSel    = sel;

endmodule

// File: tb/tb_mst_burst_engine.sv
// Bench for mst_burst_engine: word-addressed slave memory peer plus a reference memory image.
// Expected beats, addresses and read data come from the command alone (start, len+1, stride 4, wrap at 2^AW).
// Stimulus is randomized for data, alignment, lengths and stall patterns.
module tb_mst_burst_engine;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int LW = 8;
    localparam int NWORDS = (1 << AW) / 4;

    logic          iClk;
    logic          iRst_n;
    logic          iCmdValid;
    logic          oCmdReady;
    logic          iCmdWr;
    logic [AW-1:0] iCmdAddr;
    logic [LW-1:0] iCmdLen;
    logic [SW-1:0] iCmdSel;
    logic          iWrDataValid;
    logic          oWrDataReady;
    logic [DW-1:0] iWrData;
    logic          oRdDataValid;
    logic [DW-1:0] oRdData;
    logic          oBusy;
    logic          oDone;
    logic          oMstWrReq;
    logic          oMstWrValid;
    logic [AW-1:0] oMstWrAddr;
    logic [SW-1:0] oMstWrSel;
    logic [DW-1:0] oMstWrData;
    logic          iMstWrReady;
    logic          oMstRdReq;
    logic          oMstRdValid;
    logic [AW-1:0] oMstRdAddr;
    logic [SW-1:0] oMstRdSel;
    logic          iMstRdReady;
    logic [DW-1:0] iMstRdData;

    mst_burst_engine #(.AW(AW), .DW(DW), .SW(SW), .LW(LW)) dut (
        .iClk(iClk), .iRst_n(iRst_n),
        .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdWr(iCmdWr),
        .iCmdAddr(iCmdAddr), .iCmdLen(iCmdLen), .iCmdSel(iCmdSel),
        .iWrDataValid(iWrDataValid), .oWrDataReady(oWrDataReady), .iWrData(iWrData),
        .oRdDataValid(oRdDataValid), .oRdData(oRdData),
        .oBusy(oBusy), .oDone(oDone),
        .oMstWrReq(oMstWrReq), .oMstWrValid(oMstWrValid), .oMstWrAddr(oMstWrAddr),
        .oMstWrSel(oMstWrSel), .oMstWrData(oMstWrData), .iMstWrReady(iMstWrReady),
        .oMstRdReq(oMstRdReq), .oMstRdValid(oMstRdValid), .oMstRdAddr(oMstRdAddr),
        .oMstRdSel(oMstRdSel), .iMstRdReady(iMstRdReady), .iMstRdData(iMstRdData)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    // Slave memory (peer) and reference image (model)
    logic [DW-1:0] mem     [NWORDS];
    logic [DW-1:0] exp_mem [NWORDS];

    // Agent bookkeeping
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int rd_beats = 0;
    int last_rd_cyc = 0;
    int last_rdv_cyc = 0;
    int wr_rdy_mode = 0;   // 0: tied high, 1: random
    int rd_rdy_mode = 0;
    int wv_mode = 0;       // 0: always valid, 1: toggling, 2: random
    logic [DW-1:0] wq[$];
    logic [DW-1:0] wdata[$];
    logic [AW-1:0] wr_addr_log[$];
    logic [AW-1:0] rd_addr_log[$];
    int            wr_cyc_log[$];
    logic [DW-1:0] rd_got[$];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_rd[$];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < SW; b++)
            if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Slave + write-data source + read monitor, one cycle per iteration
    initial begin : agent
        bit            wa, ra, v, tog;
        logic [AW-1:0] wad, rad;
        logic [SW-1:0] ws;
        logic [DW-1:0] wd;
        tog = 1'b0;
        iMstWrReady = 1'b0; iMstRdReady = 1'b0; iWrDataValid = 1'b0;
        iWrData = '0; iMstRdData = '0;
        forever begin
            @(negedge iClk);
            cyc++;
            if (oRdDataValid) begin
                rd_got.push_back(oRdData);
                last_rdv_cyc = cyc;
            end
            if (oDone) begin
                done_cnt++;
                done_cyc = cyc;
            end
            iMstWrReady = (wr_rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            iMstRdReady = (rd_rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            tog = ~tog;
            case (wv_mode)
                0:       v = 1'b1;
                1:       v = tog;
                default: v = 1'($urandom_range(0, 1));
            endcase
            iWrDataValid = (wq.size() > 0) && v;
            iWrData      = (wq.size() > 0) ? wq[0] : '0;
            #1;
            wa = oMstWrReq && oMstWrValid && iMstWrReady;
            ra = oMstRdReq && oMstRdValid && iMstRdReady;
            wad = oMstWrAddr; ws = oMstWrSel; wd = oMstWrData;
            rad = oMstRdAddr;
            @(posedge iClk);
            #1;
            if (wa) begin
                mem[wad[AW-1:2]] = merge(mem[wad[AW-1:2]], wd, ws);
                void'(wq.pop_front());
                wr_addr_log.push_back(wad);
                wr_cyc_log.push_back(cyc);
            end
            if (ra) begin
                iMstRdData = mem[rad[AW-1:2]];
                rd_addr_log.push_back(rad);
                rd_beats++;
                last_rd_cyc = cyc;
            end
        end
    end

    task automatic issue(input bit wr, input logic [AW-1:0] a, input int len, input logic [SW-1:0] s);
        int n;
        @(negedge iClk);
        iCmdValid = 1'b1; iCmdWr = wr; iCmdAddr = a; iCmdLen = LW'(len); iCmdSel = s;
        #2;
        n = 0;
        while (!oCmdReady && n < 100) begin
            @(negedge iClk); #2; n++;
        end
        @(posedge iClk);
        #1;
        iCmdValid = 1'b0;
    endtask

    // Builds expectations from the command, drives it, waits (bounded) for oDone
    task automatic run_burst(input bit wr, input logic [AW-1:0] a, input int len,
                             input logic [SW-1:0] s, output bit ok);
        logic [AW-1:0] ba, ea;
        int base, n;
        ba = a & ~AW'(3);
        exp_addr.delete(); exp_rd.delete();
        wr_addr_log.delete(); rd_addr_log.delete(); wr_cyc_log.delete(); rd_got.delete();
        for (int i = 0; i <= len; i++) begin
            ea = ba + AW'(4 * i);
            exp_addr.push_back(ea);
            if (wr) begin
                exp_mem[ea[AW-1:2]] = merge(exp_mem[ea[AW-1:2]], wdata[i], s);
                wq.push_back(wdata[i]);
            end else begin
                exp_rd.push_back(exp_mem[ea[AW-1:2]]);
            end
        end
        base = done_cnt;
        issue(wr, a, len, s);
        n = 0;
        while (done_cnt == base && n < 5000) begin
            @(negedge iClk); #3; n++;
        end
        ok = (done_cnt > base);
    endtask

    task automatic test_reset();
        logic [6:0] hs;
        hs = {oMstWrReq, oMstWrValid, oMstRdReq, oMstRdValid, oBusy, oRdDataValid, oDone};
        checks++;
        if (hs !== 7'b0) begin errors++; $display("FAIL reset_hs: got %b expected 0000000", hs); end
        checks++;
        if ({oMstRdAddr, oMstRdSel} !== '0) begin
            errors++; $display("FAIL reset_addr_sel: got %h expected 0", {oMstRdAddr, oMstRdSel});
        end
        repeat (3) @(negedge iClk);
        iRst_n = 1'b1;
        #1;
        checks++;
        if (oCmdReady !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", oCmdReady); end
    endtask

    task automatic test_directed_write();
        bit ok;
        wr_rdy_mode = 0; wv_mode = 0;
        wdata = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_burst(1'b1, 12'h010, 3, 4'hF, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wr4_done: got no oDone expected oDone"); end
        checks++;
        if (wr_addr_log.size() != 4) begin errors++; $display("FAIL wr4_beats: got %0d expected 4", wr_addr_log.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[4 + i] !== DW'(i + 1)) begin
                errors++; $display("FAIL wr4_mem[%0d]: got %h expected %h", 4 + i, mem[4 + i], i + 1);
            end
        end
        checks++;
        if (done_cyc != wr_cyc_log[$] + 1) begin
            errors++; $display("FAIL wr4_done_timing: got cycle %0d expected %0d", done_cyc, wr_cyc_log[$] + 1);
        end
        checks++;
        if ({oBusy, oCmdReady} !== 2'b01) begin errors++; $display("FAIL wr4_idle: got %b expected 01", {oBusy, oCmdReady}); end
    endtask

    task automatic test_directed_read();
        bit ok;
        rd_rdy_mode = 0;
        run_burst(1'b0, 12'h010, 3, 4'hF, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rd4_done: got no oDone expected oDone"); end
        checks++;
        if (rd_got.size() != 4) begin errors++; $display("FAIL rd4_count: got %0d expected 4", rd_got.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= rd_got.size() || rd_got[i] !== DW'(i + 1)) begin
                errors++; $display("FAIL rd4_data[%0d]: got %h expected %h", i,
                                   (i < rd_got.size()) ? rd_got[i] : 'x, i + 1);
            end
        end
        checks++;
        if (done_cyc != last_rdv_cyc || done_cyc != last_rd_cyc + 1) begin
            errors++; $display("FAIL rd4_done_timing: got done %0d lastvalid %0d expected %0d",
                               done_cyc, last_rdv_cyc, last_rd_cyc + 1);
        end
        @(negedge iClk);
        checks++;
        if ({oRdDataValid, oBusy} !== 2'b00) begin
            errors++; $display("FAIL rd4_after: got %b expected 00", {oRdDataValid, oBusy});
        end
    endtask

    task automatic test_toggle_valid();
        bit ok;
        wr_rdy_mode = 0; wv_mode = 1;
        wdata.delete();
        for (int i = 0; i < 8; i++) wdata.push_back($urandom);
        run_burst(1'b1, 12'h100, 7, 4'hF, ok);
        checks++;
        if (!ok || wr_addr_log.size() != 8) begin
            errors++; $display("FAIL tog_beats: got %0d expected 8", wr_addr_log.size());
        end
        for (int i = 1; i < wr_addr_log.size(); i++) begin
            checks++;
            if (wr_addr_log[i] !== wr_addr_log[i-1] + AW'(4) || wr_cyc_log[i] - wr_cyc_log[i-1] != 2) begin
                errors++; $display("FAIL tog_step[%0d]: got addr %h gap %0d expected addr %h gap 2", i,
                                   wr_addr_log[i], wr_cyc_log[i] - wr_cyc_log[i-1], wr_addr_log[i-1] + AW'(4));
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[64 + i] !== wdata[i]) begin
                errors++; $display("FAIL tog_mem[%0d]: got %h expected %h", i, mem[64 + i], wdata[i]);
            end
        end
        wv_mode = 0;
    endtask

    task automatic test_wrap();
        bit ok;
        wdata = '{32'hCAFE0001, 32'hCAFE0002};
        run_burst(1'b1, 12'hFFC, 1, 4'hF, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_done: got no oDone expected oDone"); end
        checks++;
        if (wr_addr_log.size() != 2 || wr_addr_log[0] !== 12'hFFC || wr_addr_log[1] !== 12'h000) begin
            errors++; $display("FAIL wrap_addr: got %0d beats last %h expected 2 beats ffc,000",
                               wr_addr_log.size(), (wr_addr_log.size() > 0) ? wr_addr_log[$] : 'x);
        end
        checks++;
        if (mem[NWORDS-1] !== 32'hCAFE0001 || mem[0] !== 32'hCAFE0002) begin
            errors++; $display("FAIL wrap_mem: got %h,%h expected cafe0001,cafe0002", mem[NWORDS-1], mem[0]);
        end
    endtask

    task automatic test_sel();
        bit ok;
        wdata = '{32'h11223344};
        run_burst(1'b1, 12'h200, 0, 4'hF, ok);
        wdata = '{32'hAABBCCDD};
        run_burst(1'b1, 12'h200, 0, 4'b0101, ok);
        run_burst(1'b0, 12'h200, 0, 4'hF, ok);
        checks++;
        if (rd_got.size() != 1 || rd_got[0] !== 32'h11BB33DD) begin
            errors++; $display("FAIL sel_merge: got %h expected 11bb33dd", (rd_got.size() > 0) ? rd_got[0] : 'x);
        end
    endtask

    task automatic test_random();
        bit ok, wr;
        int len, bad;
        logic [AW-1:0] a;
        logic [SW-1:0] s;
        for (int t = 0; t < 24; t++) begin
            wr = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, (1 << AW) - 1));
            len = (t == 5) ? 255 : $urandom_range(0, 15);
            s = SW'($urandom_range(0, 15));
            wr_rdy_mode = $urandom_range(0, 1);
            rd_rdy_mode = $urandom_range(0, 1);
            wv_mode = $urandom_range(0, 2);
            wdata.delete();
            for (int i = 0; i <= len; i++) wdata.push_back($urandom);
            run_burst(wr, a, len, s, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rnd%0d_done: got no oDone expected oDone", t); end
            bad = 0;
            for (int i = 0; i <= len; i++) begin
                if (wr) begin
                    if (i >= wr_addr_log.size() || wr_addr_log[i] !== exp_addr[i]) bad++;
                end else begin
                    if (i >= rd_got.size() || rd_got[i] !== exp_rd[i] || rd_addr_log[i] !== exp_addr[i]) bad++;
                end
            end
            if (!wr && rd_got.size() != len + 1) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL rnd%0d_beats: got %0d bad beats (wr=%0d len=%0d) expected 0", t, bad, wr, len);
            end
        end
        bad = 0;
        for (int i = 0; i < NWORDS; i++) if (mem[i] !== exp_mem[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rnd_mem: got %0d differing words expected 0", bad); end
        wr_rdy_mode = 0; rd_rdy_mode = 0; wv_mode = 0;
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        int base, n;
        logic [6:0] hs;
        rd_rdy_mode = 0;
        base = rd_beats;
        issue(1'b0, 12'h010, 7, 4'hF);
        n = 0;
        while (rd_beats - base < 2 && n < 100) begin
            @(posedge iClk); #2; n++;
        end
        checks++;
        if (rd_beats - base < 2) begin errors++; $display("FAIL rst_mid_start: got %0d beats expected 2", rd_beats - base); end
        iRst_n = 1'b0;
        #1;
        hs = {oMstWrReq, oMstWrValid, oMstRdReq, oMstRdValid, oBusy, oRdDataValid, oDone};
        checks++;
        if (hs !== 7'b0) begin errors++; $display("FAIL rst_mid_hs: got %b expected 0000000", hs); end
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        #1;
        checks++;
        if (oCmdReady !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", oCmdReady); end
        run_burst(1'b0, 12'h010, 1, 4'hF, ok);
        checks++;
        if (!ok || rd_got.size() != 2 || rd_got[0] !== exp_rd[0] || rd_got[1] !== exp_rd[1]) begin
            errors++; $display("FAIL rst_mid_resume: got %0d words expected %h,%h", rd_got.size(), exp_rd[0], exp_rd[1]);
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        iRst_n = 1'b0; iCmdValid = 1'b0; iCmdWr = 1'b0; iCmdAddr = '0; iCmdLen = '0; iCmdSel = '0;
        for (int i = 0; i < NWORDS; i++) begin
            mem[i] = $urandom;
            exp_mem[i] = mem[i];
        end
        #1;
        test_reset();
        test_directed_write();
        test_directed_read();
        test_toggle_valid();
        test_wrap();
        test_sel();
        test_random();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
